// File: rtl/oam_dma.sv
// oam_dma: sprite OAM DMA engine.
// Halts the CPU, then copies XFER_LEN bytes from CPU page {page,8'h00} into
// the PPU OAMDATA register through the PPU CPU-register port.
// Build option: define DMA_ALIGN_EN to align the first read to an even
// (get) cycle. When it is undefined, HALT always proceeds straight to READ.
module oam_dma #(
    parameter int unsigned XFER_LEN     = 256,
    parameter logic [2:0]  OAMDATA_ADDR = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  page,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data_i,
    output logic        ppu_cs,
    output logic        ppu_rw,
    output logic [2:0]  ppu_addr,
    output logic [7:0]  ppu_data_o,
    output logic        halt,
    output logic        done
);

    localparam int unsigned IDX_W = $clog2(XFER_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       page_q;
    logic [15:0]      addr_hold;
    logic [7:0]       data_hold;
    logic             done_q;
    logic             last_write;
    logic [15:0]      rd_addr;

`ifdef DMA_ALIGN_EN
    logic cyc_odd;

    // Free-running get/put parity, counting from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_odd <= 1'b0;
        end else begin
            cyc_odd <= ~cyc_odd;
        end
    end
`endif

    assign last_write = (state == S_WRITE) && (idx == IDX_LAST);
    // High byte is always the latched page; the index never carries into it.
    assign rd_addr    = {page_q, 8'(idx)};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transfer bookkeeping: page latch, byte index, held bus values, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            page_q    <= '0;
            addr_hold <= '0;
            data_hold <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= last_write;
            if (state == S_IDLE && start) begin
                page_q <= page;
                idx    <= '0;
            end
            if (state == S_READ) begin
                addr_hold <= rd_addr;
            end
            if (state == S_WRITE) begin
                data_hold <= mem_data_i;
                idx       <= last_write ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
`ifdef DMA_ALIGN_EN
                state_nxt = cyc_odd ? S_READ : S_ALIGN;
`else
                state_nxt = S_READ;
`endif
            end
`ifdef DMA_ALIGN_EN
            S_ALIGN: begin
                state_nxt = S_READ;
            end
`endif
            S_READ: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = last_write ? S_IDLE : S_READ;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the registered state; start never reaches an output
    // combinationally. Read data passes straight through to the PPU in WRITE.
    always_comb begin
        mem_rd     = 1'b0;
        mem_addr   = addr_hold;
        ppu_cs     = 1'b0;
        ppu_rw     = 1'b1;
        ppu_addr   = '0;
        ppu_data_o = data_hold;
        case (state)
            S_READ: begin
                mem_rd   = 1'b1;
                mem_addr = rd_addr;
            end
            S_WRITE: begin
                ppu_cs     = 1'b1;
                ppu_rw     = 1'b0;
                ppu_addr   = OAMDATA_ADDR;
                ppu_data_o = mem_data_i;
            end
            default: begin
            end
        endcase
    end

    assign halt = (state != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma.
module tb_oam_dma;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  page;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data_i;
    logic        ppu_cs;
    logic        ppu_rw;
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_data_o;
    logic        halt;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic par;

    oam_dma #(.XFER_LEN(256), .OAMDATA_ADDR(3'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .page       (page),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data_i (mem_data_i),
        .ppu_cs     (ppu_cs),
        .ppu_rw     (ppu_rw),
        .ppu_addr   (ppu_addr),
        .ppu_data_o (ppu_data_o),
        .halt       (halt),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: every location holds its low address byte XOR 8'hA5; one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_data_i <= mem_addr[7:0] ^ 8'hA5;
    end

    // Bench copy of the get/put parity (0 = even/get cycle).
    always @(posedge clk or posedge rst) begin
        if (rst) par <= 1'b0;
        else     par <= ~par;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_rd"},   32'(mem_rd),   32'h0);
        chk({tag, "_ppu_cs"},   32'(ppu_cs),   32'h0);
        chk({tag, "_ppu_rw"},   32'(ppu_rw),   32'h1);
        chk({tag, "_ppu_addr"}, 32'(ppu_addr), 32'h0);
        chk({tag, "_ppu_data"}, 32'(ppu_data_o), 32'h0);
        chk({tag, "_halt"},     32'(halt),     32'h0);
        chk({tag, "_done"},     32'(done),     32'h0);
    endtask

    function automatic int exp_halt(input bit odd);
`ifdef DMA_ALIGN_EN
        return odd ? 514 : 513;
`else
        return 513;
`endif
    endfunction

    // One transfer from page pg, start on a cycle of parity want_odd.
    // poke_at: write index at which a second start (page 8'h07) is pulsed (-1 = none).
    // rst_at:  write index at which rst is asserted and the transfer abandoned (-1 = none).
    task automatic xfer(input logic [7:0] pg, input bit want_odd, input int poke_at, input int rst_at);
        int hc = 0;
        int rc = 0;
        int wc = 0;
        int dc = 0;
        int after = 0;
        @(negedge clk);
        if (par != want_odd) @(negedge clk);
        start = 1'b1;
        page  = pg;
        @(negedge clk);
        start = 1'b0;
        page  = 8'h55;
        for (int c = 0; c < 700; c++) begin
            if (start) begin
                start = 1'b0;
                page  = 8'h55;
            end
            if (halt) hc++;
            if (mem_rd) begin
                chk("rd_addr", 32'(mem_addr), 32'({pg, 8'(rc)}));
`ifdef DMA_ALIGN_EN
                chk("rd_even", 32'(par), 32'h0);
`endif
                rc++;
            end
            if (ppu_cs) begin
                chk("wr_rw",   32'(ppu_rw),     32'h0);
                chk("wr_addr", 32'(ppu_addr),   32'h4);
                chk("wr_data", 32'(ppu_data_o), 32'(8'(wc) ^ 8'hA5));
                if (wc == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk_reset_vals("midrst");
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                if (wc == poke_at) begin
                    start = 1'b1;
                    page  = 8'h07;
                end
                wc++;
            end
            if (done) begin
                dc++;
                chk("done_idle", 32'(halt), 32'h0);
            end
            if (dc > 0) after++;
            if (after > 4) break;
            @(negedge clk);
        end
        chk("halt_len",  32'(hc), 32'(exp_halt(want_odd)));
        chk("rd_count",  32'(rc), 32'd256);
        chk("wr_count",  32'(wc), 32'd256);
        chk("done_cnt",  32'(dc), 32'd1);
        chk("end_idle",  32'(halt), 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        page       = 8'h00;
        mem_data_i = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Even-cycle start, page 02.
        xfer(8'h02, 1'b0, -1, -1);

        // Reset with no transfer in flight: held bus values clear too.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("idle_rst");
        @(negedge clk);
        rst = 1'b0;

        // Odd-cycle start.
        xfer(8'h02, 1'b1, -1, -1);

        // Second start at write 50 must be ignored.
        xfer(8'h02, 1'b0, 50, -1);

        // Reset during write 100, then a fresh transfer from page 03.
        xfer(8'h02, 1'b0, -1, 100);
        xfer(8'h03, 1'b0, -1, -1);

        // Top page: last address 16'hFFFF, nothing beyond.
        xfer(8'hFF, 1'b1, -1, -1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
